regfile_sb: RTL and testbench



---
 rtl/regfile_sb_pkg.sv | 20 ++
 rtl/regfile_sb_if.sv | 44 ++++
 rtl/regfile_merge.sv | 30 +++
 rtl/regfile_sb.sv | 110 +++++++++++
 tb/tb_regfile_sb.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared constants and write-mode encoding for the register file
// Contents:
//   DEF_* defaults shared between the register file and the decoder
//   wr_mode_e  half-word merge selector used by the writeback port
package regfile_sb_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 16;
   localparam int DEF_ADDR_W   = 4;
   localparam int DEF_ZERO_REG = 14;
   localparam int DEF_NUM_RD   = 2;

   // Encoding 3 is not named: it behaves exactly like FULL.
   typedef enum logic [1:0] {
      WR_FULL = 2'd0,
      WR_LOW  = 2'd1,
      WR_HIGH = 2'd2
   } wr_mode_e;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode/writeback bus of the register file
// Signals:
//   wr_en/wr_addr/wr_data/wr_mode  writeback port
//   load_lock                      bulk ROM load in progress, blocks writeback
//   rd_addr/rd_data/rd_busy        packed operand read ports, port 0 in LSBs
//   st_addr/st_data                store-data read port
//   iss_en/iss_addr                issue of a multi-cycle producer
//   stall                          decode must hold
// Modports: master = decode/writeback side, slave = register file.
interface regfile_sb_if
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
);

   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic [1:0]               wr_mode;
   logic                     load_lock;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [ADDR_W-1:0]        st_addr;
   logic [DATA_W-1:0]        st_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     stall;

   modport master (
      output wr_en, wr_addr, wr_data, wr_mode, load_lock,
      output rd_addr, st_addr, iss_en, iss_addr,
      input  rd_data, rd_busy, st_data, stall
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_mode, load_lock,
      input  rd_addr, st_addr, iss_en, iss_addr,
      output rd_data, rd_busy, st_data, stall
   );

endinterface

// File: rtl/regfile_merge.sv
// rtl/regfile_merge.sv - half-word merge of old and new register data
// Ports:
//   mode      write mode (FULL, LOW, HIGH; 3 acts as FULL)
//   old_data  current register contents
//   new_data  writeback data
//   merged    value the register holds after the write
module regfile_merge
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] old_data,
   input  logic [DATA_W-1:0] new_data,
   output logic [DATA_W-1:0] merged
);

   localparam int HALF = DATA_W / 2;

   always_comb begin
      merged = new_data;
      case (mode)
         WR_FULL: merged = new_data;
         WR_LOW:  merged = {old_data[DATA_W-1:HALF], new_data[HALF-1:0]};
         WR_HIGH: merged = {new_data[DATA_W-1:HALF], old_data[HALF-1:0]};
         default: merged = new_data;
      endcase
   end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with zero register, bypass and busy scoreboard
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset, clears registers and busy bits
//   bus  regfile_sb_if slave: writeback, operand/store reads, issue, stall
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = DEF_ZERO_REG,
   parameter int NUM_RD   = DEF_NUM_RD
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave bus
);

   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   logic                     wr_hit;
   logic                     iss_hit;
   logic [DATA_W-1:0]        old_data;
   logic [DATA_W-1:0]        wr_merged;
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;

   // Addresses past NUM_REGS only exist when the parameters disagree.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return int'(a) < NUM_REGS;
   endfunction

   // A read of the address being written this cycle sees the write.
   function automatic logic bypass(input logic [ADDR_W-1:0] a);
      return wr_hit && (a == bus.wr_addr);
   endfunction

   function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
      if (!in_range(a) || a == ZERO_A) return '0;
      if (bypass(a)) return wr_merged;
      return regs_q[a];
   endfunction

   // A pending producer stops being a hazard in the cycle its result arrives.
   function automatic logic busy_eff(input logic [ADDR_W-1:0] a);
      if (!in_range(a)) return 1'b0;
      return busy_q[a] && !bypass(a);
   endfunction

   assign wr_hit  = bus.wr_en && !bus.load_lock && (bus.wr_addr != ZERO_A)
                    && in_range(bus.wr_addr);
   assign iss_hit = bus.iss_en && (bus.iss_addr != ZERO_A) && in_range(bus.iss_addr);

   assign old_data = in_range(bus.wr_addr) ? regs_q[bus.wr_addr] : '0;

   // One merge result feeds both the register update and every bypassed read.
   regfile_merge #(.DATA_W(DATA_W)) u_merge (
      .mode     (bus.wr_mode),
      .old_data (old_data),
      .new_data (bus.wr_data),
      .merged   (wr_merged)
   );

   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_data_c[i*DATA_W +: DATA_W] = read_val(bus.rd_addr[i*ADDR_W +: ADDR_W]);
         rd_busy_c[i]                  = busy_eff(bus.rd_addr[i*ADDR_W +: ADDR_W]);
      end
   end

   assign bus.rd_data = rd_data_c;
   assign bus.rd_busy = rd_busy_c;
   assign bus.st_data = read_val(bus.st_addr);
   // Operand RAW hazards plus WAW against a still-pending producer.
   assign bus.stall   = (|rd_busy_c) || (bus.iss_en && busy_eff(bus.iss_addr));

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr_hit) begin
         regs_d[bus.wr_addr] = wr_merged;
         busy_d[bus.wr_addr] = 1'b0;
      end
      // Applied after the clear so a same-cycle issue to the same register wins.
      if (iss_hit) begin
         busy_d[bus.iss_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
module tb_regfile_sb;
   import regfile_sb_pkg::*;

   localparam int DW  = 32;
   localparam int NR  = 16;
   localparam int AW  = 4;
   localparam int ZR  = 14;
   localparam int NRD = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD)) bus ();

   regfile_sb #(
      .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_REG(ZR), .NUM_RD(NRD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] m_reg  [16];
   logic        m_busy [16];

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [1:0]  wm;
      logic        lk;
      logic [3:0]  r0;
      logic [3:0]  r1;
      logic [3:0]  st;
      logic        ie;
      logic [3:0]  ia;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] es;
      logic [1:0]  eb;
      logic        estall;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(
      input logic we, input logic [3:0] wa, input logic [31:0] wd, input logic [1:0] wm,
      input logic lk, input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] st,
      input logic ie, input logic [3:0] ia, input logic [31:0] e0, input logic [31:0] e1,
      input logic [31:0] es, input logic [1:0] eb, input logic estall);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.wm = wm; v.lk = lk;
      v.r0 = r0; v.r1 = r1; v.st = st; v.ie = ie; v.ia = ia;
      v.e0 = e0; v.e1 = e1; v.es = es; v.eb = eb; v.estall = estall;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [1:0] wm, input logic lk, input logic [3:0] r0,
                        input logic [3:0] r1, input logic [3:0] st, input logic ie,
                        input logic [3:0] ia);
      bus.wr_en     = we;
      bus.wr_addr   = wa;
      bus.wr_data   = wd;
      bus.wr_mode   = wm;
      bus.load_lock = lk;
      bus.rd_addr   = {r1, r0};
      bus.st_addr   = st;
      bus.iss_en    = ie;
      bus.iss_addr  = ia;
   endtask

   // Reference model: architectural state plus the rules for the current inputs.
   function automatic logic m_wq();
      return bus.wr_en && !bus.load_lock && (bus.wr_addr != 4'd14);
   endfunction

   function automatic logic [31:0] m_new();
      logic [31:0] old;
      logic [31:0] d;
      old = m_reg[bus.wr_addr];
      d   = bus.wr_data;
      if (bus.wr_mode == 2'd1) return (old & 32'hFFFF0000) | (d & 32'h0000FFFF);
      if (bus.wr_mode == 2'd2) return (d & 32'hFFFF0000) | (old & 32'h0000FFFF);
      return d;
   endfunction

   function automatic logic [31:0] m_rd(input logic [3:0] a);
      if (a == 4'd14) return 32'h0;
      if (m_wq() && a == bus.wr_addr) return m_new();
      return m_reg[a];
   endfunction

   function automatic logic m_bz(input logic [3:0] a);
      return m_busy[a] && !(m_wq() && a == bus.wr_addr) && (a != 4'd14);
   endfunction

   task automatic model_step();
      logic [31:0] nv;
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (m_wq()) begin
            nv = m_new();
            m_reg[bus.wr_addr]  = nv;
            m_busy[bus.wr_addr] = 1'b0;
         end
         if (bus.iss_en && bus.iss_addr != 4'd14) m_busy[bus.iss_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_model(input int n);
      logic [3:0] a0;
      logic [3:0] a1;
      logic       exp_stall;
      a0 = bus.rd_addr[3:0];
      a1 = bus.rd_addr[7:4];
      exp_stall = m_bz(a0) || m_bz(a1) || (bus.iss_en && m_bz(bus.iss_addr));
      check($sformatf("rnd%0d rd0", n), bus.rd_data[31:0], m_rd(a0));
      check($sformatf("rnd%0d rd1", n), bus.rd_data[63:32], m_rd(a1));
      check($sformatf("rnd%0d st", n), bus.st_data, m_rd(bus.st_addr));
      check($sformatf("rnd%0d busy", n), {30'd0, bus.rd_busy}, {30'd0, m_bz(a1), m_bz(a0)});
      check($sformatf("rnd%0d stall", n), {31'd0, bus.stall}, {31'd0, exp_stall});
   endtask

   task automatic apply(input vec_t v, input int idx);
      drive(v.we, v.wa, v.wd, v.wm, v.lk, v.r0, v.r1, v.st, v.ie, v.ia);
      @(negedge clk);
      check($sformatf("v%0d rd0", idx), bus.rd_data[31:0], v.e0);
      check($sformatf("v%0d rd1", idx), bus.rd_data[63:32], v.e1);
      check($sformatf("v%0d st", idx), bus.st_data, v.es);
      check($sformatf("v%0d busy", idx), {30'd0, bus.rd_busy}, {30'd0, v.eb});
      check($sformatf("v%0d stall", idx), {31'd0, bus.stall}, {31'd0, v.estall});
      tick();
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 4'd0, 32'h0, 2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
      tick();
      tick();
      rst = 1'b0;

      //              we    wa     wd            wm    lk    r0     r1     st     ie    ia     e0            e1            es            eb     stall
      vecs[0]  = mk(1'b0, 4'd0,  32'h0,        2'd0, 1'b0, 4'd0,  4'd15, 4'd3,  1'b0, 4'd0,  32'h0,        32'h0,        32'h0,        2'b00, 1'b0);
      vecs[1]  = mk(1'b1, 4'd3,  32'hDEADBEEF, 2'd0, 1'b0, 4'd3,  4'd1,  4'd3,  1'b0, 4'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 1'b0);
      vecs[2]  = mk(1'b1, 4'd3,  32'h12340000, 2'd2, 1'b0, 4'd3,  4'd3,  4'd0,  1'b0, 4'd0,  32'h1234BEEF, 32'h1234BEEF, 32'h0,        2'b00, 1'b0);
      vecs[3]  = mk(1'b1, 4'd3,  32'h00005678, 2'd1, 1'b0, 4'd3,  4'd0,  4'd3,  1'b0, 4'd0,  32'h12345678, 32'h0,        32'h12345678, 2'b00, 1'b0);
      vecs[4]  = mk(1'b0, 4'd0,  32'h0,        2'd0, 1'b0, 4'd3,  4'd3,  4'd3,  1'b0, 4'd0,  32'h12345678, 32'h12345678, 32'h12345678, 2'b00, 1'b0);
      vecs[5]  = mk(1'b1, 4'd14, 32'hFFFFFFFF, 2'd0, 1'b0, 4'd14, 4'd3,  4'd14, 1'b1, 4'd14, 32'h0,        32'h12345678, 32'h0,        2'b00, 1'b0);
      vecs[6]  = mk(1'b0, 4'd0,  32'h0,        2'd0, 1'b0, 4'd14, 4'd14, 4'd14, 1'b0, 4'd0,  32'h0,        32'h0,        32'h0,        2'b00, 1'b0);
      vecs[7]  = mk(1'b1, 4'd5,  32'hA5A5A5A5, 2'd3, 1'b0, 4'd5,  4'd0,  4'd5,  1'b0, 4'd0,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 2'b00, 1'b0);
      vecs[8]  = mk(1'b1, 4'd5,  32'h12345678, 2'd0, 1'b1, 4'd5,  4'd5,  4'd5,  1'b0, 4'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0);
      vecs[9]  = mk(1'b0, 4'd0,  32'h0,        2'd0, 1'b0, 4'd5,  4'd0,  4'd0,  1'b1, 4'd7,  32'hA5A5A5A5, 32'h0,        32'h0,        2'b00, 1'b0);
      vecs[10] = mk(1'b0, 4'd0,  32'h0,        2'd0, 1'b0, 4'd7,  4'd0,  4'd7,  1'b0, 4'd0,  32'h0,        32'h0,        32'h0,        2'b01, 1'b1);
      vecs[11] = mk(1'b1, 4'd7,  32'h00000077, 2'd0, 1'b1, 4'd3,  4'd7,  4'd7,  1'b0, 4'd0,  32'h12345678, 32'h0,        32'h0,        2'b10, 1'b1);
      vecs[12] = mk(1'b1, 4'd7,  32'h00000077, 2'd0, 1'b0, 4'd3,  4'd7,  4'd7,  1'b0, 4'd0,  32'h12345678, 32'h77,       32'h77,       2'b00, 1'b0);
      vecs[13] = mk(1'b0, 4'd0,  32'h0,        2'd0, 1'b0, 4'd3,  4'd7,  4'd0,  1'b0, 4'd0,  32'h12345678, 32'h77,       32'h0,        2'b00, 1'b0);
      vecs[14] = mk(1'b1, 4'd7,  32'h00000088, 2'd0, 1'b0, 4'd7,  4'd0,  4'd0,  1'b1, 4'd7,  32'h88,       32'h0,        32'h0,        2'b00, 1'b0);
      vecs[15] = mk(1'b0, 4'd0,  32'h0,        2'd0, 1'b0, 4'd7,  4'd7,  4'd7,  1'b0, 4'd0,  32'h88,       32'h88,       32'h88,       2'b11, 1'b1);
      vecs[16] = mk(1'b0, 4'd0,  32'h0,        2'd0, 1'b0, 4'd3,  4'd3,  4'd3,  1'b1, 4'd7,  32'h12345678, 32'h12345678, 32'h12345678, 2'b00, 1'b1);
      vecs[17] = mk(1'b1, 4'd7,  32'h00990000, 2'd2, 1'b0, 4'd7,  4'd0,  4'd7,  1'b1, 4'd7,  32'h00990088, 32'h0,        32'h00990088, 2'b00, 1'b0);
      vecs[18] = mk(1'b1, 4'd2,  32'h00000055, 2'd0, 1'b0, 4'd2,  4'd7,  4'd2,  1'b1, 4'd2,  32'h55,       32'h00990088, 32'h55,       2'b10, 1'b1);

      for (int i = 0; i < 19; i++) begin
         apply(vecs[i], i);
      end

      // r2 holds 0x55 and is busy; reset with a competing write and issue.
      drive(1'b0, 4'd0, 32'h0, 2'd0, 1'b0, 4'd2, 4'd0, 4'd2, 1'b0, 4'd0);
      @(negedge clk);
      check("pre_rst r2", bus.rd_data[31:0], 32'h55);
      check("pre_rst busy", {30'd0, bus.rd_busy}, 32'h1);
      check("pre_rst stall", {31'd0, bus.stall}, 32'h1);
      tick();
      rst = 1'b1;
      drive(1'b1, 4'd2, 32'hFF, 2'd0, 1'b0, 4'd2, 4'd9, 4'd3, 1'b1, 4'd9);
      tick();
      rst = 1'b0;
      drive(1'b0, 4'd0, 32'h0, 2'd0, 1'b0, 4'd2, 4'd9, 4'd3, 1'b1, 4'd2);
      @(negedge clk);
      check("post_rst r2", bus.rd_data[31:0], 32'h0);
      check("post_rst r9", bus.rd_data[63:32], 32'h0);
      check("post_rst st", bus.st_data, 32'h0);
      check("post_rst busy", {30'd0, bus.rd_busy}, 32'h0);
      check("post_rst stall", {31'd0, bus.stall}, 32'h0);
      tick();

      // Randomized traffic against the reference model.
      rst = 1'b1;
      drive(1'b0, 4'd0, 32'h0, 2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
      tick();
      rst = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic [3:0] wa;
         logic [3:0] r0;
         logic [3:0] r1;
         logic [3:0] st;
         wa = 4'($urandom_range(0, 15));
         r0 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
         r1 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
         st = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 99) == 0);
         drive(1'($urandom_range(0, 1)), wa, 32'($urandom()), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), r0, r1, st,
               ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
         @(negedge clk);
         if (!rst) check_model(n);
         tick();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
